// File: rtl/instr_prefetch_unit_pkg.sv
// instr_prefetch_unit_pkg: shared widths, reset PC and fetch state encoding
package instr_prefetch_unit_pkg;
  localparam int DATASIZE = 32;
  localparam logic [DATASIZE-1:0] RESET_PC = '0;
  localparam int INSTR_BYTES = 4;
  typedef enum logic {FETCH, DISCARD} fetch_state_e;
endpackage

// File: rtl/instr_prefetch_unit_if.sv
// instr_prefetch_unit_if: instruction memory req/ack read bus
interface instr_prefetch_unit_if;
  logic req;
  logic ack;
  logic [instr_prefetch_unit_pkg::DATASIZE-1:0] addr;
  logic [instr_prefetch_unit_pkg::DATASIZE-1:0] rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/instr_prefetch_unit_fetch_fifo.sv
// fetch_fifo: sync FIFO with clear, extra-MSB pointers, zero output when empty
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign dout = (count == '0) ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: fetch stage issuing imem reads into a PC-tagged FIFO for decode
module instr_prefetch_unit
  import instr_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_d,
  input  logic                 redirect_valid,
  input  logic [DATASIZE-1:0]  redirect_pc,
  instr_prefetch_unit_if.master imem,
  output logic                 instr_valid,
  output logic [DATASIZE-1:0]  instr_out,
  output logic [DATASIZE-1:0]  pc_out,
  output logic [DATASIZE-1:0]  pc_plus4_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  fetch_state_e state, state_nx;
  logic [DATASIZE-1:0] fetch_pc, stale_addr;
  logic [2*DATASIZE-1:0] head;
  logic [AW:0] count;
  logic acc, push, pop;
  // A read is only launched when a slot is free, so the slot is reserved until its ack
  always_comb begin
    imem.req = reset && (state == DISCARD || count < FULL);
    imem.addr = state == DISCARD ? stale_addr : fetch_pc;
    acc = imem.req && imem.ack;
    push = acc && state == FETCH && !redirect_valid;
    pop = instr_valid && !stall_d && !redirect_valid;
    state_nx = (redirect_valid && state == FETCH && imem.req && !acc) ? DISCARD :
               acc ? FETCH : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      fetch_pc <= RESET_PC;
      stale_addr <= RESET_PC;
    end else begin
      state <= state_nx;
      if (redirect_valid) fetch_pc <= redirect_pc & ~DATASIZE'(INSTR_BYTES - 1);
      else if (push) fetch_pc <= fetch_pc + DATASIZE'(INSTR_BYTES);
      if (state == FETCH) stale_addr <= fetch_pc;
    end
  fetch_fifo #(.W(2*DATASIZE), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(redirect_valid),
    .push(push),
    .pop(pop),
    .din({fetch_pc, imem.rdata}),
    .dout(head),
    .count(count)
  );
  assign {pc_out, instr_out} = head;
  assign instr_valid = count != '0;
  assign pc_plus4_out = pc_out + DATASIZE'(INSTR_BYTES);
endmodule
